alu_mul_sequencer: RTL

- Multi-cycle controller that computes a 16x16 -> 16-bit (low half) product using only the shared 16-bit Hack ALU.
- Runs shift-and-add: the ALU is issued x+y operations, multiplier shifting is done internally, and the ALU result is captured each cycle.
- Sits beside the ALU in the CPU datapath. A parent module instantiates the ALU and wires this block's alu_* ports to it while a multiply runs.
- Low 16 bits are identical for signed and unsigned operands, so no sign handling is needed.

---
 rtl/hack_alu_pkg.sv | 23 ++
 rtl/hack_alu.sv | 25 ++
 rtl/alu_mul_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack ALU and the blocks that sequence it.
package hack_alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_OP_ADD  = 6'b000010;
    localparam alu_ctrl_t ALU_OP_ZERO = 6'b101010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational 16-bit Hack ALU; the multiply sequencer borrows it via its parent.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, x2, y1, y2, r;

    assign x1  = zx ? 16'h0000 : x;
    assign x2  = nx ? ~x1 : x1;
    assign y1  = zy ? 16'h0000 : y;
    assign y2  = ny ? ~y1 : y1;
    assign r   = f ? (x2 + y2) : (x2 & y2);
    assign out = no ? ~r : r;
    assign zr  = (out == 16'h0000);
    assign ng  = out[15];
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 -> 16 multiply that issues x+y operations to an external Hack ALU.
// state | meaning
// IDLE  | waiting for start; ALU driven to constant 0
// ADD   | acc <= acc + mcand
// DBL   | mcand <= mcand + mcand, multiplier shifts right, bit index advances
// DONE  | product <= acc, one-cycle done pulse
module alu_mul_sequencer
    import hack_alu_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             prod_zr,
    output logic             prod_ng,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);
    mul_state_t       state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mult;
    logic [3:0]       count;
    logic [WIDTH-1:0] mult_shr;
    logic [3:0]       count_inc;
    alu_ctrl_t        ctrl;

    assign mult_shr  = mult >> 1;
    assign count_inc = count + 4'd1;

    // DBL decides on the post-shift multiplier and post-increment index.
    always_comb begin
        state_nxt = state;
        alu_x     = '0;
        alu_y     = '0;
        ctrl      = ALU_OP_ZERO;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_b[0])
                        state_nxt = ADD;
                    else if (EARLY_EXIT && (op_b == '0))
                        state_nxt = DONE;
                    else
                        state_nxt = DBL;
                end
            end
            ADD: begin
                alu_x = acc;
                alu_y = mcand;
                ctrl  = ALU_OP_ADD;
                if ((count == 4'd15) || (EARLY_EXIT && (mult[WIDTH-1:1] == '0)))
                    state_nxt = DONE;
                else
                    state_nxt = DBL;
            end
            DBL: begin
                alu_x = mcand;
                alu_y = mcand;
                ctrl  = ALU_OP_ADD;
                if (EARLY_EXIT && (mult_shr == '0))
                    state_nxt = DONE;
                else if (mult_shr[0])
                    state_nxt = ADD;
                else if (count_inc == 4'd15)
                    state_nxt = DONE;
                else
                    state_nxt = DBL;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mult    <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        mcand   <= op_a;
                        mult    <= op_b;
                        count   <= '0;
                        product <= '0;
                    end
                end
                ADD:  acc <= alu_out;
                DBL: begin
                    mcand <= alu_out;
                    mult  <= mult_shr;
                    count <= count_inc;
                end
                DONE: product <= acc;
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign prod_zr = (product == '0);
    assign prod_ng = product[WIDTH-1];
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

endmodule
